// File: rtl/vlc_pkg.sv
// Shared definitions for the vector list controller: layout of the 57-bit
// vector word, the null vector returned past the end of a list, RGB565
// colour constants and a small coordinate clamp helper.
package vlc_pkg;

  // Widths of the fields in one display-list entry
  localparam int VEC_W   = 57;
  localparam int COORD_W = 10;
  localparam int COL_W   = 16;

  // Bit offsets of each field inside the packed word
  localparam int X0_LSB   = 0;
  localparam int Y0_LSB   = 10;
  localparam int X1_LSB   = 20;
  localparam int Y1_LSB   = 30;
  localparam int COL_LSB  = 40;
  localparam int LAST_BIT = 56;

  // Field order matches the host word {last, col, y1, x1, y0, x0}
  typedef struct packed {
    logic               last;
    logic [COL_W-1:0]   col;
    logic [COORD_W-1:0] y1;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x0;
  } vec_word_t;

  // Returned for any index at or beyond the active count: zero-length,
  // black, and flagged as the end of the list so the drawer stops.
  localparam vec_word_t NULL_VECTOR = '{
    last: 1'b1,
    col:  '0,
    y1:   '0,
    x1:   '0,
    y0:   '0,
    x0:   '0
  };

  // RGB565 primaries
  localparam logic [COL_W-1:0] RGB565_RED   = 16'hF800;
  localparam logic [COL_W-1:0] RGB565_GREEN = 16'h07E0;
  localparam logic [COL_W-1:0] RGB565_BLUE  = 16'h001F;

  // Saturate a coordinate at the screen edge
  function automatic logic [COORD_W-1:0] clamp_coord(
    input logic [COORD_W-1:0] value,
    input logic [COORD_W-1:0] limit
  );
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/vlc_dpram.sv
// Simple dual-port RAM holding both display-list banks (2*DEPTH words).
// The upper address bit selects the bank. One write port for the host,
// one registered read port for the line drawer. No reset on the array or
// the read register so the tools can map it onto block RAM.
module vlc_dpram
  import vlc_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW:0]      wr_addr,
  input  logic [VEC_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW:0]      rd_addr,
  output logic [VEC_W-1:0] rd_data
);

  localparam int WORDS = 2 * DEPTH;

  logic [VEC_W-1:0] mem [WORDS];
  logic [VEC_W-1:0] rd_data_q;

  // Host write and drawer read; read data holds when no read is issued
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/vector_list_ctrl.sv
// Double-buffered display-list controller. The host fills the back bank,
// pulses commit, and the banks swap at the next frame start (vtrigger)
// provided the line drawer is not in the middle of walking the front list;
// otherwise the swap is deferred and counted as an overrun.
// Optional build macro VECTOR_LIST_CLIP_EN clamps output coordinates to
// XMAX/YMAX; without it coordinates pass through untouched.
module vector_list_ctrl
  import vlc_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
`ifdef VECTOR_LIST_CLIP_EN
  ,
  parameter int XMAX  = 639,
  parameter int YMAX  = 479
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [VEC_W-1:0] wr_data,
  input  logic             commit,
  input  logic [AW:0]      commit_cnt,
  output logic             busy,
  output logic             swap_ack,
  output logic [15:0]      overrun_cnt,
  input  logic             vtrigger,
  input  logic [9:0]       vector,
  input  logic             read_vector,
  output logic [9:0]       x0,
  output logic [9:0]       y0,
  output logic [9:0]       x1,
  output logic [9:0]       y1,
  output logic [15:0]      col,
  output logic             last_vector
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  // Bank and list bookkeeping
  logic        front_q, front_d;
  logic [AW:0] active_cnt_q, active_cnt_d;
  logic [AW:0] pend_cnt_q, pend_cnt_d;
  logic        busy_q, busy_d;
  logic        swap_ack_q, swap_ack_d;
  logic [15:0] overrun_cnt_q, overrun_cnt_d;

  // Frame tracking: armed after vtrigger, busy from first read to last word
  logic        armed_q, armed_d;
  logic        frame_busy_q, frame_busy_d;

  // Read-side side information captured alongside the RAM read
  logic        null_sel_q, null_sel_d;
  logic        cnt_last_q, cnt_last_d;
  logic        deliver_q, deliver_d;

  logic [AW:0]      commit_clamped;
  logic             busy_eff;
  logic [AW:0]      pend_eff;
  logic             do_swap;
  logic             do_defer;
  logic [10:0]      vec_ext;
  logic [10:0]      cnt_ext;
  logic             read_is_null;
  logic             read_is_end;
  logic [VEC_W-1:0] ram_rd_data;
  vec_word_t        ram_word;
  vec_word_t        out_word;

  assign commit_clamped = (commit_cnt > DEPTH_CNT) ? DEPTH_CNT : commit_cnt;

  // A commit arriving on the vtrigger cycle counts as already pending
  assign busy_eff = busy_q | commit;
  assign pend_eff = busy_q ? pend_cnt_q : commit_clamped;
  assign do_swap  = vtrigger & busy_eff & ~frame_busy_q;
  assign do_defer = vtrigger & busy_eff & frame_busy_q;

  assign vec_ext      = 11'(vector);
  assign cnt_ext      = 11'(active_cnt_q);
  assign read_is_null = (vec_ext >= cnt_ext);
  assign read_is_end  = (vec_ext == (cnt_ext - 11'd1));

  // Host writes go to the back bank, drawer reads come from the front bank
  vlc_dpram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en & ~busy_q),
    .wr_addr ({~front_q, wr_addr}),
    .wr_data (wr_data),
    .rd_en   (read_vector),
    .rd_addr ({front_q, vector[AW-1:0]}),
    .rd_data (ram_rd_data)
  );

  assign ram_word = vec_word_t'(ram_rd_data);
  assign out_word = null_sel_q ? NULL_VECTOR : ram_word;

  // Commit latching, bank swap or deferral on vtrigger, overrun counting
  always_comb begin
    front_d       = front_q;
    active_cnt_d  = active_cnt_q;
    pend_cnt_d    = pend_cnt_q;
    busy_d        = busy_q;
    swap_ack_d    = do_swap;
    overrun_cnt_d = overrun_cnt_q;
    if (do_swap) begin
      front_d      = ~front_q;
      active_cnt_d = pend_eff;
      busy_d       = 1'b0;
    end else if (busy_eff) begin
      busy_d     = 1'b1;
      pend_cnt_d = pend_eff;
    end
    if (do_defer && (overrun_cnt_q != 16'hFFFF)) begin
      overrun_cnt_d = overrun_cnt_q + 16'd1;
    end
  end

  // Frame is open from the first read after vtrigger until an end word is
  // delivered; a new frame starting in the same cycle takes precedence
  always_comb begin
    armed_d      = vtrigger | (armed_q & ~read_vector);
    frame_busy_d = frame_busy_q;
    if (deliver_q && last_vector) begin
      frame_busy_d = 1'b0;
    end
    if (read_vector && armed_q) begin
      frame_busy_d = 1'b1;
    end
  end

  // Capture null/end-of-count flags with the read so they line up with RAM data
  always_comb begin
    null_sel_d = null_sel_q;
    cnt_last_d = cnt_last_q;
    deliver_d  = read_vector;
    if (read_vector) begin
      null_sel_d = read_is_null;
      cnt_last_d = read_is_end & ~read_is_null;
    end
  end

  // State registers; reset presents the null vector immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      front_q       <= 1'b0;
      active_cnt_q  <= '0;
      pend_cnt_q    <= '0;
      busy_q        <= 1'b0;
      swap_ack_q    <= 1'b0;
      overrun_cnt_q <= '0;
      armed_q       <= 1'b0;
      frame_busy_q  <= 1'b0;
      null_sel_q    <= 1'b1;
      cnt_last_q    <= 1'b0;
      deliver_q     <= 1'b0;
    end else begin
      front_q       <= front_d;
      active_cnt_q  <= active_cnt_d;
      pend_cnt_q    <= pend_cnt_d;
      busy_q        <= busy_d;
      swap_ack_q    <= swap_ack_d;
      overrun_cnt_q <= overrun_cnt_d;
      armed_q       <= armed_d;
      frame_busy_q  <= frame_busy_d;
      null_sel_q    <= null_sel_d;
      cnt_last_q    <= cnt_last_d;
      deliver_q     <= deliver_d;
    end
  end

  assign busy        = busy_q;
  assign swap_ack    = swap_ack_q;
  assign overrun_cnt = overrun_cnt_q;
  assign col         = out_word.col;
  assign last_vector = out_word.last | cnt_last_q;

`ifdef VECTOR_LIST_CLIP_EN
  assign x0 = clamp_coord(out_word.x0, COORD_W'(XMAX));
  assign y0 = clamp_coord(out_word.y0, COORD_W'(YMAX));
  assign x1 = clamp_coord(out_word.x1, COORD_W'(XMAX));
  assign y1 = clamp_coord(out_word.y1, COORD_W'(YMAX));
`else
  assign x0 = out_word.x0;
  assign y0 = out_word.y0;
  assign x1 = out_word.x1;
  assign y1 = out_word.y1;
`endif

endmodule

// File: tb/tb_vector_list_ctrl.sv
// Testbench for vector_list_ctrl: a hand-derived vector table, directed
// sequences for deferral, dropped writes, same-cycle commit/swap, count
// clamping and async reset, then randomized traffic against a list model.
module tb_vector_list_ctrl;
  import vlc_pkg::*;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [AW-1:0] wr_addr;
  logic [56:0] wr_data;
  logic        commit;
  logic [AW:0] commit_cnt;
  logic        busy;
  logic        swap_ack;
  logic [15:0] overrun_cnt;
  logic        vtrigger;
  logic [9:0]  vector;
  logic        read_vector;
  logic [9:0]  x0, y0, x1, y1;
  logic [15:0] col;
  logic        last_vector;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  vector_list_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .commit      (commit),
    .commit_cnt  (commit_cnt),
    .busy        (busy),
    .swap_ack    (swap_ack),
    .overrun_cnt (overrun_cnt),
    .vtrigger    (vtrigger),
    .vector      (vector),
    .read_vector (read_vector),
    .x0          (x0),
    .y0          (y0),
    .x1          (x1),
    .y1          (y1),
    .col         (col),
    .last_vector (last_vector)
  );

  // Reference model: two banks of list entries, which one is shown, how
  // long the shown list is, a pending list, and whether the drawer is
  // currently walking a frame.
  logic [56:0] m_mem [2][DEPTH];
  int          m_front, m_active, m_pend, m_overrun;
  bit          m_busy, m_ack, m_frame_open, m_wait_first_read, m_delivered;
  logic [56:0] e_word;
  bit          e_last;

  function automatic logic [56:0] mk(input int ax0, input int ay0, input int ax1,
                                     input int ay1, input logic [15:0] c, input bit l);
    logic [56:0] w;
    w = '0;
    w[X0_LSB +: 10]  = 10'(ax0);
    w[Y0_LSB +: 10]  = 10'(ay0);
    w[X1_LSB +: 10]  = 10'(ax1);
    w[Y1_LSB +: 10]  = 10'(ay1);
    w[COL_LSB +: 16] = c;
    w[LAST_BIT]      = l;
    return w;
  endfunction

  function automatic logic [9:0] lim(input logic [9:0] v, input int m);
`ifdef VECTOR_LIST_CLIP_EN
    if (int'(v) > m) return 10'(m);
`endif
    return v;
  endfunction

  function automatic logic [56:0] clipWord(input logic [56:0] w);
    logic [56:0] r;
    r = w;
    r[X0_LSB +: 10] = lim(w[X0_LSB +: 10], 639);
    r[Y0_LSB +: 10] = lim(w[Y0_LSB +: 10], 479);
    r[X1_LSB +: 10] = lim(w[X1_LSB +: 10], 639);
    r[Y1_LSB +: 10] = lim(w[Y1_LSB +: 10], 479);
    return r;
  endfunction

  function automatic logic [56:0] outWord();
    return {last_vector, col, y1, x1, y0, x0};
  endfunction

  task automatic modelReset();
    m_front = 0; m_active = 0; m_pend = 0; m_overrun = 0;
    m_busy = 0; m_ack = 0; m_frame_open = 0; m_wait_first_read = 0;
    m_delivered = 0;
    e_word = NULL_VECTOR;
    e_last = 1'b1;
  endtask

  // One clock of list semantics, evaluated from the inputs just sampled
  task automatic modelStep();
    bit closing, starting, pending;
    int pend_now, idx;
    closing  = m_delivered && e_last;
    starting = read_vector && m_wait_first_read;
    pending  = m_busy || commit;
    pend_now = m_busy ? m_pend : ((int'(commit_cnt) > DEPTH) ? DEPTH : int'(commit_cnt));
    if (read_vector) begin
      idx = int'(vector);
      if (idx >= m_active) begin
        e_word = NULL_VECTOR;
        e_last = 1'b1;
      end else begin
        e_word = m_mem[m_front][idx];
        e_last = e_word[LAST_BIT] || (idx == m_active - 1);
      end
    end
    if (wr_en && !m_busy) m_mem[1 - m_front][int'(wr_addr)] = wr_data;
    m_delivered = read_vector;
    m_ack = 0;
    if (vtrigger && pending && !m_frame_open) begin
      m_front  = 1 - m_front;
      m_active = pend_now;
      m_busy   = 0;
      m_ack    = 1;
    end else if (vtrigger && pending) begin
      if (m_overrun < 65535) m_overrun++;
      m_busy = 1;
      m_pend = pend_now;
    end else if (pending) begin
      m_busy = 1;
      m_pend = pend_now;
    end
    if (starting) m_frame_open = 1;
    else if (closing) m_frame_open = 0;
    m_wait_first_read = vtrigger || (m_wait_first_read && !read_vector);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    n_compared++;
    if (got !== want) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Drive one cycle of inputs, clock it, update the model and compare
  task automatic applyStimulus(input bit we, input int wa, input logic [56:0] wd,
                               input bit cm, input int cc, input bit vt,
                               input bit rd, input int vec);
    logic [56:0] ew;
    wr_en = we; wr_addr = AW'(wa); wr_data = wd;
    commit = cm; commit_cnt = (AW+1)'(cc);
    vtrigger = vt; read_vector = rd; vector = 10'(vec);
    @(posedge clk);
    modelStep();
    #1;
    ew = clipWord(e_word);
    checkOutput("model_status", 64'({busy, swap_ack, overrun_cnt}),
                64'({m_busy, m_ack, 16'(m_overrun)}));
    checkOutput("model_last", 64'(last_vector), 64'(e_last));
    checkOutput("model_data", 64'(outWord() & 57'h0FF_FFFF_FFFF_FFFF),
                64'(ew & 57'h0FF_FFFF_FFFF_FFFF));
    wr_en = 0; commit = 0; vtrigger = 0; read_vector = 0;
  endtask

  task automatic doIdle();                         applyStimulus(0, 0, '0, 0, 0, 0, 0, 0); endtask
  task automatic doWrite(input int a, input logic [56:0] d); applyStimulus(1, a, d, 0, 0, 0, 0, 0); endtask
  task automatic doRead(input int v);              applyStimulus(0, 0, '0, 0, 0, 0, 1, v); endtask
  task automatic doCommit(input int c);            applyStimulus(0, 0, '0, 1, c, 0, 0, 0); endtask
  task automatic doVtrig();                        applyStimulus(0, 0, '0, 0, 0, 1, 0, 0); endtask

  typedef struct {
    bit          we;
    int          wa;
    logic [56:0] wd;
    bit          cm;
    int          cc;
    bit          vt;
    bit          rd;
    int          vec;
    logic [56:0] ew;
    bit          eb;
    bit          ea;
  } vec_row_t;

  initial begin
    vec_row_t    tbl[11];
    logic [56:0] nullw, wa_, wb_, wc_, wd_, we_, wg_, dexp;
    logic [56:0] wf[5];
    logic [63:0] r;

    nullw = NULL_VECTOR;
    wa_ = mk(10, 20, 30, 40, RGB565_RED, 0);
    wb_ = mk(100, 110, 120, 130, RGB565_GREEN, 0);
    wc_ = mk(200, 210, 300, 310, RGB565_BLUE, 0);
    wd_ = mk(5, 6, 700, 500, RGB565_RED, 0);
    we_ = mk(1, 2, 3, 4, RGB565_GREEN, 0);
    wg_ = mk(11, 22, 33, 44, RGB565_RED, 0);
`ifdef VECTOR_LIST_CLIP_EN
    dexp = mk(5, 6, 639, 479, RGB565_RED, 0);
`else
    dexp = mk(5, 6, 700, 500, RGB565_RED, 0);
`endif
    for (int i = 0; i < 5; i++) wf[i] = mk(i, i + 1, i + 2, i + 3, RGB565_BLUE, 0);

    //           we wa wd   cm cc vt rd vec  expected word              busy ack
    tbl[0]  = '{0, 0, '0,  0, 0, 0, 1, 5,   nullw,                      0, 0};
    tbl[1]  = '{1, 0, wa_, 0, 0, 0, 0, 0,   nullw,                      0, 0};
    tbl[2]  = '{1, 1, wb_, 0, 0, 0, 0, 0,   nullw,                      0, 0};
    tbl[3]  = '{1, 2, wc_, 0, 0, 0, 0, 0,   nullw,                      0, 0};
    tbl[4]  = '{0, 0, '0,  1, 3, 0, 0, 0,   nullw,                      1, 0};
    tbl[5]  = '{0, 0, '0,  0, 0, 1, 0, 0,   nullw,                      0, 1};
    tbl[6]  = '{0, 0, '0,  0, 0, 0, 0, 0,   nullw,                      0, 0};
    tbl[7]  = '{0, 0, '0,  0, 0, 0, 1, 0,   wa_,                        0, 0};
    tbl[8]  = '{0, 0, '0,  0, 0, 0, 1, 1,   wb_,                        0, 0};
    tbl[9]  = '{0, 0, '0,  0, 0, 0, 1, 2,   wc_ | (57'd1 << LAST_BIT),  0, 0};
    tbl[10] = '{0, 0, '0,  0, 0, 0, 1, 3,   nullw,                      0, 0};

    wr_en = 0; wr_addr = '0; wr_data = '0; commit = 0; commit_cnt = '0;
    vtrigger = 0; read_vector = 0; vector = '0;
    reset = 1'b1;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset_state", 64'({outWord(), busy, swap_ack, overrun_cnt}),
                64'({nullw, 1'b0, 1'b0, 16'd0}));

    $display("[TB] table vectors");
    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].cm, tbl[i].cc,
                    tbl[i].vt, tbl[i].rd, tbl[i].vec);
      checkOutput($sformatf("tbl_word[%0d]", i), 64'(outWord()), 64'(tbl[i].ew));
      checkOutput($sformatf("tbl_status[%0d]", i), 64'({busy, swap_ack}), 64'({tbl[i].eb, tbl[i].ea}));
    end

    $display("[TB] deferred swap and dropped writes");
    doVtrig();
    doRead(0);
    doRead(1);
    doWrite(0, wd_);
    doWrite(1, we_);
    doCommit(2);
    doVtrig();
    checkOutput("overrun_after_defer", 64'({overrun_cnt, swap_ack, busy}), 64'({16'd1, 1'b0, 1'b1}));
    doWrite(0, mk(9, 9, 9, 9, RGB565_GREEN, 1));
    doWrite(1, mk(8, 8, 8, 8, RGB565_RED, 1));
    doRead(2);
    checkOutput("frame_end_word", 64'(outWord()), 64'(wc_ | (57'd1 << LAST_BIT)));
    doIdle();
    doVtrig();
    checkOutput("retry_swap_ack", 64'({swap_ack, busy}), 64'({1'b1, 1'b0}));
    doRead(0);
    checkOutput("new_list_0_clip", 64'(outWord()), 64'(dexp));
    doRead(1);
    checkOutput("new_list_1_last", 64'(outWord()), 64'(we_ | (57'd1 << LAST_BIT)));
    doRead(2);
    checkOutput("new_list_2_null", 64'(outWord()), 64'(nullw));

    $display("[TB] commit and vtrigger together");
    for (int i = 0; i < 5; i++) doWrite(i, wf[i]);
    applyStimulus(0, 0, '0, 1, 5, 1, 0, 0);
    checkOutput("same_cycle_ack", 64'({swap_ack, busy}), 64'({1'b1, 1'b0}));
    doRead(4);
    checkOutput("cnt5_idx4", 64'(outWord()), 64'(wf[4] | (57'd1 << LAST_BIT)));
    doRead(3);
    checkOutput("cnt5_idx3", 64'(outWord()), 64'(wf[3]));
    doRead(5);
    checkOutput("cnt5_idx5", 64'(outWord()), 64'(nullw));

    $display("[TB] commit count clamp");
    doWrite(1023, wg_);
    doCommit(2000);
    doVtrig();
    doRead(1023);
    checkOutput("clamp_idx1023", 64'(outWord()), 64'(wg_ | (57'd1 << LAST_BIT)));

    $display("[TB] async reset mid-frame");
    reset = 1'b1;
    #1;
    checkOutput("async_reset_out", 64'({outWord(), busy, swap_ack, overrun_cnt}),
                64'({nullw, 1'b0, 1'b0, 16'd0}));
    modelReset();
    @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] prefill both banks");
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < 40; a++) begin
        r = {$urandom, $urandom};
        r[LAST_BIT] = ($urandom_range(0, 7) == 0);
        doWrite(a, r[56:0]);
      end
      doCommit(40);
      doVtrig();
    end

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      bit we, cm, vt, rd;
      int cc;
      r = {$urandom, $urandom};
      r[LAST_BIT] = ($urandom_range(0, 7) == 0);
      we = ($urandom_range(0, 3) == 0);
      cm = ($urandom_range(0, 29) == 0);
      cc = ($urandom_range(0, 9) == 0) ? 2000 : $urandom_range(0, 41);
      vt = ((i % 37) == 0);
      rd = ($urandom_range(0, 1) == 1);
      applyStimulus(we, $urandom_range(0, 39), r[56:0], cm, cc, vt, rd, $urandom_range(0, 39));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
